sum_window_accumulator: RTL and testbench
=========================================

# sum_window_accumulator

Streaming accumulator that sits directly downstream of the ripple-carry adder stage. It consumes (DATA_WIDTH+1)-bit sums over a valid/ready handshake and accumulates them over fixed windows of NUM_SAMPLES accepted samples. For each window it emits three results on an output handshake: the total, the largest sum seen, and the number of sums whose carry bit was set. Working state and the output register are separate, so the next window accumulates while the previous result waits for the consumer.

## Interface
- DATA_WIDTH, 8, adder operand width; input sums are DATA_WIDTH+1 bits
- NUM_SAMPLES, 4, samples per window; must be at least 1
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_sum is valid
- in_ready  output  1  block can accept in_sum this cycle
- in_sum  input  DATA_WIDTH+1  adder result; MSB is the carry-out
- clear  input  1  synchronous abort of the current working window
- out_valid  output  1  window result is held on out_*
- out_ready  input  1  consumer takes the result
- out_acc  output  ACC_WIDTH  sum of the window's samples
- out_max  output  DATA_WIDTH+1  largest sample in the window (unsigned)
- out_carries  output  CAR_WIDTH  count of samples with in_sum[DATA_WIDTH]=1

## Operation
- Widths:
  - ACC_WIDTH = DATA_WIDTH+1+$clog2(NUM_SAMPLES). This is sized so the accumulator cannot overflow.
  - CAR_WIDTH = $clog2(NUM_SAMPLES+1).
  - CNT_WIDTH = max(1, $clog2(NUM_SAMPLES)).
- Working state: acc_w, max_w, car_w, and cnt, the number of samples accepted in the current window (0..NUM_SAMPLES-1).
- Accept means in_valid && in_ready. On accept:
  - acc_w += in_sum
  - max_w = max(max_w, in_sum)
  - car_w += in_sum[DATA_WIDTH]
  - cnt += 1
- Window completion happens on an accept when cnt == NUM_SAMPLES-1. On that cycle:
  - out_acc, out_max and out_carries load the updated values, including the completing sample.
  - out_valid is set.
  - All working state returns to 0.
- Output handshake: out_valid && out_ready clears out_valid. out_* values stay stable while out_valid=1 and are not changed by the transfer.
- Simultaneous completion and transfer: a window may complete in the same cycle the held result transfers. The new result loads and out_valid stays 1.
- in_ready = !rst && !clear && (!out_valid || out_ready || cnt != NUM_SAMPLES-1).
  - The path from out_ready to in_ready is combinational, which is permitted.
  - Effect: stall only when the next accept would complete a window while the output is still occupied.
- clear:
  - Zeroes acc_w, max_w, car_w and cnt.
  - Forces in_ready=0, so any sample presented that cycle is dropped.
  - Does not touch out_valid or out_*.
- NUM_SAMPLES=1: cnt stays 0 and every accept completes a window.

## Timing
- Reset (rst=1 at an edge) sets:
  - out_valid=0, out_acc=0, out_max=0, out_carries=0
  - all working state to 0
- in_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Reset in mid-window or with a pending output discards both; no partial result is emitted.
- Latency: if the completing sample is accepted at edge T, out_valid=1 from T+1.
- Throughput: one sample per cycle sustained when out_ready=1, with no bubbles between windows.
- Backpressure: with out_ready=0, at most NUM_SAMPLES-1 further samples are accepted after the held result. in_ready then drops until the transfer.
- out_* are registered. in_ready is the only combinational output.

## Structure
- Package sum_accum_pkg holds the width functions for ACC_WIDTH, CAR_WIDTH and CNT_WIDTH, computed from DATA_WIDTH and NUM_SAMPLES. The bench shares them.
- Single module with no sub-module. The accumulator add is a plain `+`.

## Test plan
All scenarios use DATA_WIDTH=8 and NUM_SAMPLES=4.
- Reset: hold rst for 3 cycles.
  - During rst: in_ready=0, out_valid=0, out_acc=out_max=out_carries=0.
  - First cycle after rst: in_ready=1.
- Basic window: send 10, 20, 30, 40 back-to-back with out_ready=1.
  - out_valid=1 one cycle after 40 is accepted.
  - out_acc=100, out_max=40, out_carries=0.
  - out_valid drops on the next cycle.
- Extremes: send 510, 510, 256, 0.
  - out_acc=1276, out_max=510, out_carries=3.
- Backpressure: out_ready=0, send 1..8.
  - First result is held with out_acc=10.
  - Samples 5, 6, 7 are accepted; in_ready=0 while 8 is presented.
  - Raise out_ready: transfer 10, then 8 is accepted, then out_acc=26 is presented.
- Clear: send 5, 5, then pulse clear together with in_valid (sample 99), then send 1, 2, 3, 4.
  - 99 is dropped.
  - out_acc=10, out_max=4.
- Reset mid-operation: hold a pending result plus 2 working samples, then assert rst.
  - out_valid=0 after rst.
  - A fresh window of 7, 7, 7, 7 yields out_acc=28.

Source files
------------

// File: rtl/sum_window_accumulator_pkg.sv
// Width helpers shared by the window accumulator, its interface and its bench.
// Every width is derived from the adder operand width and the window length.
package sum_accum_pkg;

  // Sized so that NUM_SAMPLES maximal sums can never overflow the accumulator.
  function automatic int acc_width(input int data_width, input int num_samples);
    return data_width + 1 + $clog2(num_samples);
  endfunction

  function automatic int car_width(input int num_samples);
    return $clog2(num_samples + 1);
  endfunction

  function automatic int cnt_width(input int num_samples);
    return (num_samples <= 1) ? 1 : $clog2(num_samples);
  endfunction

endpackage

// File: rtl/sum_window_accumulator_if.sv
// Input sum stream and windowed result stream of the accumulator.
// The slave view belongs to the accumulator; the master view belongs to the producer/consumer side.
interface sum_window_accumulator_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 4
) ();
  import sum_accum_pkg::*;

  localparam int SW = DATA_WIDTH + 1;
  localparam int AW = acc_width(DATA_WIDTH, NUM_SAMPLES);
  localparam int CW = car_width(NUM_SAMPLES);

  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_sum;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic [SW-1:0] out_max;
  logic [CW-1:0] out_carries;

  modport slave (
    input  in_valid, in_sum, clear, out_ready,
    output in_ready, out_valid, out_acc, out_max, out_carries
  );

  modport master (
    output in_valid, in_sum, clear, out_ready,
    input  in_ready, out_valid, out_acc, out_max, out_carries
  );

endinterface

// File: rtl/sum_window_accumulator.sv
// Accumulates total, maximum and carry count of adder sums over fixed windows.
// The working window and the held result are separate registers so accumulation overlaps the output wait.
module sum_window_accumulator
  import sum_accum_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  sum_window_accumulator_if.slave bus
);

  localparam int SW = DATA_WIDTH + 1;
  localparam int AW = acc_width(DATA_WIDTH, NUM_SAMPLES);
  localparam int CW = car_width(NUM_SAMPLES);
  localparam int NW = cnt_width(NUM_SAMPLES);
  localparam logic [NW-1:0] LAST_CNT = NW'(NUM_SAMPLES - 1);

  logic [AW-1:0] r_acc;
  logic [SW-1:0] r_max;
  logic [CW-1:0] r_car;
  logic [NW-1:0] r_cnt;

  logic          r_out_valid;
  logic [AW-1:0] r_out_acc;
  logic [SW-1:0] r_out_max;
  logic [CW-1:0] r_out_car;

  logic          w_last;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_xfer;
  logic [AW-1:0] w_acc_nxt;
  logic [SW-1:0] w_max_nxt;
  logic [CW-1:0] w_car_nxt;

  // Stall only when the next sample would complete a window into an occupied output.
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_in_ready = !rst && !bus.clear && (!r_out_valid || bus.out_ready || !w_last);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_xfer     = r_out_valid && bus.out_ready;

  assign w_acc_nxt = r_acc + AW'(bus.in_sum);
  assign w_max_nxt = (bus.in_sum > r_max) ? bus.in_sum : r_max;
  assign w_car_nxt = r_car + CW'(bus.in_sum[SW-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_max       <= '0;
      r_car       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_max   <= '0;
      r_out_car   <= '0;
    end else begin
      // Completion is evaluated after the transfer so a same-cycle new result keeps out_valid high.
      if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (bus.clear) begin
        r_acc <= '0;
        r_max <= '0;
        r_car <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_out_valid <= 1'b1;
          r_out_acc   <= w_acc_nxt;
          r_out_max   <= w_max_nxt;
          r_out_car   <= w_car_nxt;
          r_acc       <= '0;
          r_max       <= '0;
          r_car       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_acc_nxt;
          r_max <= w_max_nxt;
          r_car <= w_car_nxt;
          r_cnt <= r_cnt + NW'(1);
        end
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_acc     = r_out_acc;
  assign bus.out_max     = r_out_max;
  assign bus.out_carries = r_out_car;

endmodule

// File: tb/tb_sum_window_accumulator.sv
// Bench for sum_window_accumulator: directed window table, corner sequences and random traffic
// checked every cycle against a queue-based window model.
module tb_sum_window_accumulator;
  import sum_accum_pkg::*;

  localparam int DW = 8;
  localparam int NS = 4;
  localparam int SW = DW + 1;
  localparam int AW = acc_width(DW, NS);
  localparam int CW = car_width(NS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_window_accumulator_if #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS)) bus ();

  sum_window_accumulator #(.DATA_WIDTH(DW), .NUM_SAMPLES(NS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: samples of the open window plus the held result.
  logic [SW-1:0] win[$];
  logic          m_ov;
  int            m_acc, m_max, m_car;
  logic          m_rdy;
  logic          last_in_ready;

  typedef struct {
    int s[4];
    int acc;
    int mx;
    int car;
  } win_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void win_result(output int a, output int mx, output int c);
    a = 0; mx = 0; c = 0;
    foreach (win[i]) begin
      a += int'(win[i]);
      if (int'(win[i]) > mx) mx = int'(win[i]);
      if (win[i] >= SW'(1 << DW)) c++;
    end
  endfunction

  // One clock: drive after the edge, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle(input logic v, input int s, input logic c, input logic r);
    int a, mx, cr;
    bus.in_valid  = v;
    bus.in_sum    = SW'(s);
    bus.clear     = c;
    bus.out_ready = r;
    m_rdy = !c && (!m_ov || r || (win.size() != NS - 1));
    @(negedge clk);
    last_in_ready = bus.in_ready;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
    if (m_ov) begin
      chk("out_acc", 32'(bus.out_acc), 32'(m_acc));
      chk("out_max", 32'(bus.out_max), 32'(m_max));
      chk("out_carries", 32'(bus.out_carries), 32'(m_car));
    end
    @(posedge clk);
    if (m_ov && r) m_ov = 1'b0;
    if (c) win.delete();
    else if (v && m_rdy) begin
      win.push_back(SW'(s));
      if (win.size() == NS) begin
        win_result(a, mx, cr);
        m_acc = a; m_max = mx; m_car = cr;
        m_ov  = 1'b1;
        win.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sum = '0; bus.clear = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_acc", 32'(bus.out_acc), 32'd0);
      chk("rst_out_max", 32'(bus.out_max), 32'd0);
      chk("rst_out_carries", 32'(bus.out_carries), 32'd0);
      if (i < n - 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    win.delete();
    m_ov = 1'b0; m_acc = 0; m_max = 0; m_car = 0;
  endtask

  task automatic chk_out(input string nm, input logic ov, input int a, input int mx, input int c);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
    chk({nm, "_acc"}, 32'(bus.out_acc), 32'(a));
    chk({nm, "_max"}, 32'(bus.out_max), 32'(mx));
    chk({nm, "_car"}, 32'(bus.out_carries), 32'(c));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    win_vec_t tbl[3];
    tbl[0] = '{s: '{10, 20, 30, 40},    acc: 100,  mx: 40,  car: 0};
    tbl[1] = '{s: '{510, 510, 256, 0},  acc: 1276, mx: 510, car: 3};
    tbl[2] = '{s: '{255, 1, 256, 257},  acc: 769,  mx: 257, car: 2};

    m_ov = 1'b0; m_acc = 0; m_max = 0; m_car = 0; last_in_ready = 1'b0;
    do_reset(3);
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed windows, back-to-back with the consumer always ready.
    foreach (tbl[k]) begin
      for (int i = 0; i < NS; i++) cycle(1'b1, tbl[k].s[i], 1'b0, 1'b1);
      chk_out($sformatf("tbl%0d", k), 1'b1, tbl[k].acc, tbl[k].mx, tbl[k].car);
      cycle(1'b0, 0, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_drop", k), {31'd0, bus.out_valid}, 32'd0);
    end

    // Backpressure: the held result blocks only the window-completing sample.
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 1'b0);
    chk_out("bp_first", 1'b1, 10, 4, 0);
    for (int i = 5; i <= 7; i++) begin
      cycle(1'b1, i, 1'b0, 1'b0);
      chk($sformatf("bp_acc_s%0d", i), {31'd0, last_in_ready}, 32'd1);
    end
    cycle(1'b1, 8, 1'b0, 1'b0);
    chk("bp_stall8", {31'd0, last_in_ready}, 32'd0);
    cycle(1'b1, 8, 1'b0, 1'b0);
    chk("bp_stall8b", {31'd0, last_in_ready}, 32'd0);
    chk_out("bp_hold", 1'b1, 10, 4, 0);
    cycle(1'b1, 8, 1'b0, 1'b1);
    chk("bp_take8", {31'd0, last_in_ready}, 32'd1);
    chk_out("bp_second", 1'b1, 26, 8, 0);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Clear drops the in-flight sample and the partial window.
    cycle(1'b1, 5, 1'b0, 1'b1);
    cycle(1'b1, 5, 1'b0, 1'b1);
    cycle(1'b1, 99, 1'b1, 1'b1);
    chk("clr_ready", {31'd0, last_in_ready}, 32'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 1'b0, 1'b1);
    chk_out("clr_win", 1'b1, 10, 4, 0);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Reset with a held result and a partial window discards both.
    for (int i = 0; i < NS + 2; i++) cycle(1'b1, 300 + i, 1'b0, 1'b0);
    chk("mid_pending", {31'd0, bus.out_valid}, 32'd1);
    do_reset(2);
    chk("mid_ov_after_rst", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < NS; i++) cycle(1'b1, 7, 1'b0, 1'b1);
    chk_out("mid_fresh", 1'b1, 28, 7, 0);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, (1 << SW) - 1)),
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
